// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, register-number constants and types for the MIPS pipeline
package mips_pkg;
    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     word_t;

    localparam reg_addr_t REG_ZERO = 5'd0;
    localparam reg_addr_t REG_SP   = 5'd29;
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one register-file read port with $zero masking and optional WB write-through
//   rst      - synchronous reset; a write in a reset cycle is never bypassed
//   rd_addr  - read address
//   arr_data - array entry selected by rd_addr
//   wr_en, wr_addr, wr_data - WB write port, used only for write-through
//   rd_data  - read result
// Macro REGFILE_BYPASS_EN enables same-cycle write-through of WB data.
module regfile_read_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] arr_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);
    import mips_pkg::*;

    logic is_zero;
    assign is_zero = rd_addr == ADDR_W'(REG_ZERO);

`ifdef REGFILE_BYPASS_EN
    // A non-zero read address implies a non-zero write address on a hit.
    logic hit;
    assign hit = !rst && wr_en && (wr_addr == rd_addr);
    always_comb rd_data = is_zero ? '0 : hit ? wr_data : arr_data;
`else
    logic unused_bypass;
    assign unused_bypass = &{1'b0, rst, wr_en, wr_addr, wr_data};
    always_comb rd_data = is_zero ? '0 : arr_data;
`endif
endmodule

// File: rtl/mips_register_file.sv
// mips_register_file: 32-entry MIPS GPR file, two ID read ports, one WB write port, one debug read port
//   clk, rst                          - clock, synchronous active-high reset
//   RegAddrX_ID/RegDataX_ID           - operand X (rs) read port
//   RegAddrY_ID/RegDataY_ID           - operand Y (rt) read port
//   RegWrite_WB/RegAddr_WB/RegData_WB - WB write port, 1-edge latency
//   RegAddr_DBG/RegData_DBG           - debug read port
// Macro REGFILE_BYPASS_EN enables write-through on all three read ports.
module mips_register_file #(
    parameter int                 DATA_W   = 32,
    parameter int                 ADDR_W   = 5,
    parameter int                 NUM_REGS = 32,
    parameter logic [DATA_W-1:0]  SP_RESET = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] RegAddrX_ID,
    input  logic [ADDR_W-1:0] RegAddrY_ID,
    output logic [DATA_W-1:0] RegDataX_ID,
    output logic [DATA_W-1:0] RegDataY_ID,
    input  logic              RegWrite_WB,
    input  logic [ADDR_W-1:0] RegAddr_WB,
    input  logic [DATA_W-1:0] RegData_WB,
    input  logic [ADDR_W-1:0] RegAddr_DBG,
    output logic [DATA_W-1:0] RegData_DBG
);
    import mips_pkg::*;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (RegWrite_WB && RegAddr_WB != ADDR_W'(REG_ZERO))
            regs_d[RegAddr_WB] = RegData_WB;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= (i == int'(REG_SP)) ? SP_RESET : '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_x (
        .rst(rst), .rd_addr(RegAddrX_ID), .arr_data(regs_q[RegAddrX_ID]),
        .wr_en(RegWrite_WB), .wr_addr(RegAddr_WB), .wr_data(RegData_WB), .rd_data(RegDataX_ID)
    );

    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_y (
        .rst(rst), .rd_addr(RegAddrY_ID), .arr_data(regs_q[RegAddrY_ID]),
        .wr_en(RegWrite_WB), .wr_addr(RegAddr_WB), .wr_data(RegData_WB), .rd_data(RegDataY_ID)
    );

    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_dbg (
        .rst(rst), .rd_addr(RegAddr_DBG), .arr_data(regs_q[RegAddr_DBG]),
        .wr_en(RegWrite_WB), .wr_addr(RegAddr_WB), .wr_data(RegData_WB), .rd_data(RegData_DBG)
    );
endmodule

// File: tb/tb_mips_register_file.sv
// tb_mips_register_file: scoreboard-driven self-checking bench for mips_register_file
module tb_mips_register_file;
    import mips_pkg::*;

    localparam word_t SP_INIT = 32'h0000_3FFC;

    logic      clk = 1'b0;
    logic      rst = 1'b0;
    reg_addr_t RegAddrX_ID = '0, RegAddrY_ID = '0, RegAddr_WB = '0, RegAddr_DBG = '0;
    word_t     RegDataX_ID, RegDataY_ID, RegData_WB = '0, RegData_DBG;
    logic      RegWrite_WB = 1'b0;

    typedef struct {
        reg_addr_t addr;
        word_t     data;
        string     name;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mips_register_file #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .SP_RESET(SP_INIT)) dut (
        .clk(clk), .rst(rst),
        .RegAddrX_ID(RegAddrX_ID), .RegAddrY_ID(RegAddrY_ID),
        .RegDataX_ID(RegDataX_ID), .RegDataY_ID(RegDataY_ID),
        .RegWrite_WB(RegWrite_WB), .RegAddr_WB(RegAddr_WB), .RegData_WB(RegData_WB),
        .RegAddr_DBG(RegAddr_DBG), .RegData_DBG(RegData_DBG)
    );

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.push_back('{5'd29, SP_INIT, "reset_sp"});
        sb.push_back('{5'd1, 32'h0, "reset_r1"});
        sb.push_back('{5'd31, 32'h0, "reset_r31"});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            RegAddr_DBG = e.addr;
            #1;
            checks++;
            if (RegData_DBG !== e.data) $display("FAIL %s: got %h expected %h", e.name, RegData_DBG, e.data);
            else passed++;
        end
    endtask

    task automatic test_write_read();
        word_t same_cycle;
        @(negedge clk);
        RegAddrX_ID = 5'd8;
        RegWrite_WB = 1'b1;
        RegAddr_WB  = 5'd8;
        RegData_WB  = 32'hDEAD_BEEF;
        sb.push_back('{5'd8, 32'hDEAD_BEEF, "write_r8"});
`ifdef REGFILE_BYPASS_EN
        same_cycle = 32'hDEAD_BEEF;
`else
        same_cycle = 32'h0;
`endif
        #1;
        checks++;
        if (RegDataX_ID !== same_cycle) $display("FAIL write_same_cycle: got %h expected %h", RegDataX_ID, same_cycle);
        else passed++;
        @(negedge clk);
        RegWrite_WB = 1'b0;
        e = sb.pop_front();
        RegAddrX_ID = e.addr;
        #1;
        checks++;
        if (RegDataX_ID !== e.data) $display("FAIL %s: got %h expected %h", e.name, RegDataX_ID, e.data);
        else passed++;
    endtask

    task automatic test_zero();
        @(negedge clk);
        RegWrite_WB = 1'b1;
        RegAddr_WB  = 5'd0;
        RegData_WB  = 32'hFFFF_FFFF;
        RegAddrX_ID = 5'd0;
        RegAddrY_ID = 5'd0;
        RegAddr_DBG = 5'd0;
        #1;
        checks++;
        if ({RegDataX_ID, RegDataY_ID, RegData_DBG} !== 96'h0)
            $display("FAIL zero_same_cycle: got %h %h %h expected 0", RegDataX_ID, RegDataY_ID, RegData_DBG);
        else passed++;
        sb.push_back('{5'd0, 32'h0, "zero_after"});
        @(negedge clk);
        RegWrite_WB = 1'b0;
        e = sb.pop_front();
        #1;
        checks++;
        if (RegDataX_ID !== e.data) $display("FAIL %s_x: got %h expected %h", e.name, RegDataX_ID, e.data);
        else passed++;
        checks++;
        if (RegDataY_ID !== e.data) $display("FAIL %s_y: got %h expected %h", e.name, RegDataY_ID, e.data);
        else passed++;
        checks++;
        if (RegData_DBG !== e.data) $display("FAIL %s_dbg: got %h expected %h", e.name, RegData_DBG, e.data);
        else passed++;
    endtask

    task automatic test_write_disable();
        @(negedge clk);
        RegWrite_WB = 1'b0;
        RegAddr_WB  = 5'd5;
        RegData_WB  = 32'h1234_5678;
        RegAddrY_ID = 5'd5;
        sb.push_back('{5'd5, 32'h0, "wr_disabled"});
        #1;
        checks++;
        if (RegDataY_ID !== 32'h0) $display("FAIL wr_disabled_same_cycle: got %h expected %h", RegDataY_ID, 32'h0);
        else passed++;
        @(negedge clk);
        e = sb.pop_front();
        RegAddr_DBG = e.addr;
        #1;
        checks++;
        if (RegDataY_ID !== e.data) $display("FAIL %s_y: got %h expected %h", e.name, RegDataY_ID, e.data);
        else passed++;
        checks++;
        if (RegData_DBG !== e.data) $display("FAIL %s_dbg: got %h expected %h", e.name, RegData_DBG, e.data);
        else passed++;
    endtask

    task automatic test_reset_wins();
        @(negedge clk);
        RegWrite_WB = 1'b1;
        RegAddr_WB  = 5'd9;
        RegData_WB  = 32'hAAAA_AAAA;
        sb.push_back('{5'd9, 32'hAAAA_AAAA, "r9_before_reset"});
        @(negedge clk);
        RegWrite_WB = 1'b0;
        e = sb.pop_front();
        RegAddrX_ID = e.addr;
        #1;
        checks++;
        if (RegDataX_ID !== e.data) $display("FAIL %s: got %h expected %h", e.name, RegDataX_ID, e.data);
        else passed++;
        @(negedge clk);
        rst         = 1'b1;
        RegWrite_WB = 1'b1;
        RegAddr_WB  = 5'd9;
        RegData_WB  = 32'h5555_5555;
        #1;
        checks++;
        if (RegDataX_ID !== 32'hAAAA_AAAA) $display("FAIL reset_cycle_no_bypass: got %h expected %h", RegDataX_ID, 32'hAAAA_AAAA);
        else passed++;
        sb.push_back('{5'd9, 32'h0, "reset_wins_r9"});
        sb.push_back('{5'd29, SP_INIT, "reset_wins_sp"});
        @(negedge clk);
        rst         = 1'b0;
        RegWrite_WB = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            RegAddr_DBG = e.addr;
            #1;
            checks++;
            if (RegData_DBG !== e.data) $display("FAIL %s: got %h expected %h", e.name, RegData_DBG, e.data);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        word_t d;
        for (int a = 1; a < 32; a++) begin
            @(negedge clk);
            d = $urandom;
            RegWrite_WB = 1'b1;
            RegAddr_WB  = reg_addr_t'(a);
            RegData_WB  = d;
            sb.push_back('{reg_addr_t'(a), d, "b2b"});
        end
        @(negedge clk);
        RegWrite_WB = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            RegAddrX_ID = e.addr;
            RegAddr_DBG = e.addr;
            #1;
            checks++;
            if (RegDataX_ID !== e.data) $display("FAIL %s_x r%0d: got %h expected %h", e.name, e.addr, RegDataX_ID, e.data);
            else passed++;
            checks++;
            if (RegData_DBG !== e.data) $display("FAIL %s_dbg r%0d: got %h expected %h", e.name, e.addr, RegData_DBG, e.data);
            else passed++;
        end
    endtask

    task automatic test_dual_read();
        @(negedge clk);
        RegWrite_WB = 1'b1;
        RegAddr_WB  = 5'd17;
        RegData_WB  = 32'h0000_00A5;
        sb.push_back('{5'd17, 32'h0000_00A5, "dual_r17"});
        @(negedge clk);
        RegWrite_WB = 1'b0;
        e = sb.pop_front();
        RegAddrX_ID = e.addr;
        RegAddrY_ID = e.addr;
        RegAddr_DBG = e.addr;
        #1;
        checks++;
        if (RegDataX_ID !== e.data) $display("FAIL %s_x: got %h expected %h", e.name, RegDataX_ID, e.data);
        else passed++;
        checks++;
        if (RegDataY_ID !== e.data) $display("FAIL %s_y: got %h expected %h", e.name, RegDataY_ID, e.data);
        else passed++;
        checks++;
        if (RegData_DBG !== e.data) $display("FAIL %s_dbg: got %h expected %h", e.name, RegData_DBG, e.data);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero();
        test_write_disable();
        test_reset_wins();
        test_back_to_back();
        test_dual_read();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/mips_register_file.md
Name: mips_register_file

Overview:
- 32-entry general-purpose register file for the pipelined MIPS core.
- Two combinational read ports serve the ID stage. Their outputs are the un-forwarded operands that the ID-stage forwarding unit overrides with EX/MEM/WB results.
- One synchronous write port is driven by the WB stage.
- A third read-only debug port lets the testbench and top-level observe architectural state.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width
- NUM_REGS, 32, number of registers (must equal 2**ADDR_W)
- SP_RESET, 32'h0000_0000, reset value loaded into register 29 ($sp); every other register resets to 0

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- RegAddrX_ID  input  ADDR_W  read address, operand X (rs)
- RegAddrY_ID  input  ADDR_W  read address, operand Y (rt)
- RegDataX_ID  output  DATA_W  register contents for X; feeds forwarding-unit X data input
- RegDataY_ID  output  DATA_W  register contents for Y; feeds forwarding-unit Y data input
- RegWrite_WB  input  1  write enable from WB stage
- RegAddr_WB  input  ADDR_W  write address from WB stage
- RegData_WB  input  DATA_W  write data from WB stage
- RegAddr_DBG  input  ADDR_W  debug read address
- RegData_DBG  output  DATA_W  debug read data

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high. The polarity and synchronicity are fixed.
- Storage: NUM_REGS x DATA_W flip-flop array; no memory macro.
- Reset:
  - On a rising edge with rst=1, every register clears to 0, except register 29, which loads SP_RESET.
  - A write presented in the same cycle as reset is discarded; reset wins.
  - Reset asserted mid-program takes effect at the next edge, regardless of any in-flight write.
- Write:
  - On a rising edge with rst=0 and RegWrite_WB=1 and RegAddr_WB!=0, the array entry at RegAddr_WB takes RegData_WB.
  - Latency is 1 edge.
  - RegWrite_WB=0 leaves the array unchanged.
- Register 0:
  - Reads always return 0 on every port.
  - Writes to address 0 are ignored; no storage is updated.
- Read:
  - All three read ports are purely combinational (asynchronous) from the array.
  - There is no read enable and no handshake.
- Same-cycle read/write, same address, no bypass (see Optional Feature): reads return the pre-write value until the edge. The forwarding unit's WB path covers this hazard.
- Output values:
  - Before the first reset edge, outputs are X apart from register 0.
  - After reset, outputs are 0 for all addresses except 29, which reads SP_RESET.
- Widths: no arithmetic. The address decode is a full ADDR_W compare, so no aliasing is possible.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: internal write-through on all three read ports. If RegWrite_WB=1, RegAddr_WB!=0, RegAddr_WB equals the read address, and rst=0, the port returns RegData_WB in the same cycle. Address 0 still reads 0.
- Undefined: the same-cycle read returns the old array contents, and the forwarding unit's WB path supplies the new value.
- The array update timing is identical in both builds.

Decomposition:
- Shared package mips_pkg holds:
  - DATA_W and REG_ADDR_W constants
  - REG_ZERO=5'd0 and REG_SP=5'd29
  - typedef reg_addr_t (logic [4:0]) and word_t (logic [31:0])
  - The forwarding unit and pipeline registers import the same package.
- Sub-module: one natural sub-module, regfile_read_port, instantiated three times. It contains the address-0 masking and the optional bypass mux, so the bypass logic is written once.

Test Plan:
- Reset with SP_RESET=32'h0000_3FFC: after one rst=1 edge, RegAddr_DBG=29 reads 32'h0000_3FFC and addresses 1 and 31 read 0.
- Write 32'hDEAD_BEEF to register 8, then set RegAddrX_ID=8 on the next cycle -> RegDataX_ID=32'hDEAD_BEEF. In the write cycle itself, RegDataX_ID is the old value without the macro and 32'hDEAD_BEEF with REGFILE_BYPASS_EN.
- RegWrite_WB=1, RegAddr_WB=0, RegData_WB=32'hFFFF_FFFF -> RegDataX_ID, RegDataY_ID and RegData_DBG at address 0 all stay 0, in both builds.
- RegWrite_WB=0 with RegAddr_WB=5 and data 32'h1234_5678 -> register 5 is unchanged and still reads its prior value 32'h0000_0000.
- Register 9 holds 32'hAAAA_AAAA; raise rst together with a write of 32'h5555_5555 to 9 -> after the edge, register 9 reads 0 (reset wins).
- RegAddrX_ID=RegAddrY_ID=17 with register 17 holding 32'h0000_00A5 -> both ports read 32'h0000_00A5 simultaneously; debug port at 17 agrees.
